// File: rtl/mem_write_arbiter_if.sv
// mem_write_arbiter_if: two requester write ports plus the Avalon-MM write master they share.
interface mem_write_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req0_write;
    logic [ADDR_WIDTH-1:0]   req0_addr;
    logic [DATA_WIDTH-1:0]   req0_data;
    logic                    req0_waitrequest;
    logic                    req1_write;
    logic [ADDR_WIDTH-1:0]   req1_addr;
    logic [DATA_WIDTH-1:0]   req1_data;
    logic                    req1_waitrequest;
    logic [ADDR_WIDTH-1:0]   master_address;
    logic                    master_write;
    logic [DATA_WIDTH/8-1:0] master_byteenable;
    logic [DATA_WIDTH-1:0]   master_writedata;
    logic                    master_waitrequest;
    logic                    grant_id;
    logic                    busy;

    modport master (
        input  req0_write, req0_addr, req0_data, req1_write, req1_addr, req1_data, master_waitrequest,
        output req0_waitrequest, req1_waitrequest, master_address, master_write, master_byteenable,
               master_writedata, grant_id, busy
    );

    modport slave (
        output req0_write, req0_addr, req0_data, req1_write, req1_addr, req1_data, master_waitrequest,
        input  req0_waitrequest, req1_waitrequest, master_address, master_write, master_byteenable,
               master_writedata, grant_id, busy
    );
endinterface

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: sticky round-robin arbiter of two write requesters onto one Avalon-MM write master.
module mem_write_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_GRANT  = 4
) (
    input logic                 clk,
    input logic                 reset,
    mem_write_arbiter_if.master bus
);
    typedef enum logic {IDLE, ISSUE} state_t;
    localparam logic [3:0] MAX = 4'(MAX_GRANT);

    state_t     state;
    logic       owner;
    logic [3:0] count;
    logic       accept;
    logic       winner;
    logic       grant;

    // Owner keeps the port while both request until it has used MAX_GRANT slots in a row.
    always_comb begin
        winner = (bus.req0_write && bus.req1_write) ? ((count == MAX) ? ~owner : owner) : bus.req1_write;
        accept = !reset && (state == IDLE || !bus.master_waitrequest);
        grant  = accept && (bus.req0_write || bus.req1_write);
    end

    assign bus.req0_waitrequest  = ~(grant && !winner);
    assign bus.req1_waitrequest  = ~(grant && winner);
    assign bus.master_byteenable = {(DATA_WIDTH/8){1'b1}};
    assign bus.busy              = bus.master_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            owner                <= 1'b0;
            count                <= 4'd0;
            bus.master_write     <= 1'b0;
            bus.master_address   <= {ADDR_WIDTH{1'b0}};
            bus.master_writedata <= {DATA_WIDTH{1'b0}};
            bus.grant_id         <= 1'b0;
        end else if (grant) begin
            state                <= ISSUE;
            bus.master_write     <= 1'b1;
            bus.master_address   <= winner ? bus.req1_addr : bus.req0_addr;
            bus.master_writedata <= winner ? bus.req1_data : bus.req0_data;
            bus.grant_id         <= winner;
            if (winner == owner) begin
                count <= (count == MAX) ? MAX : count + 4'd1;
            end else begin
                owner <= winner;
                count <= 4'd1;
            end
        end else if (accept) begin
            state            <= IDLE;
            bus.master_write <= 1'b0;
        end
    end
endmodule
